// File: rtl/waiter_nav_fsm.sv
// -----------------------------------------------------------------------------
// waiter_nav_fsm
// Navigation sequencer for the waiter robot. Runs one delivery cycle
// (base -> table -> base) made of timed legs (FORWARDS, TURN, BACKWARDS,
// TURN_BACK) and sensor-terminated legs (TO_TABLE, RETURN_HOME). An obstacle
// seen in any moving state parks the robot in STOP. It then resumes the
// interrupted leg with its timer intact once the path has been clear long
// enough.
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   go            in   1-cycle pulse, order received (FFT tone detector)
//   obstacle      in   level, path blocked (camera)
//   near          in   level, target within slow-down distance
//   arrived       in   level, target reached (table or base)
//   pickup        in   1-cycle pulse, customer collected the order
//   state   [3:0] out  registered robot state code
//   speed   [2:0] out  registered speed code for the motor stage
//   state_changed out  registered 1-cycle pulse on every state transition
// -----------------------------------------------------------------------------
module waiter_nav_fsm #(
  parameter int unsigned FWD_CYCLES   = 100_000_000,
  parameter int unsigned TURN_CYCLES  = 40_000_000,
  parameter int unsigned BACK_CYCLES  = 100_000_000,
  parameter int unsigned CLEAR_CYCLES = 25_000_000,
  parameter logic [2:0]  SPEED_NORMAL = 3'd4,
  parameter logic [2:0]  SPEED_SLOW   = 3'd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic       obstacle,
  input  logic       near,
  input  logic       arrived,
  input  logic       pickup,
  output logic [3:0] state,
  output logic [2:0] speed,
  output logic       state_changed
);

  localparam int unsigned MAX_FT  = (FWD_CYCLES > TURN_CYCLES) ? FWD_CYCLES : TURN_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_FT > BACK_CYCLES) ? MAX_FT : BACK_CYCLES;
  // A count of 1 needs no bits; keep at least one so the vectors stay legal.
  localparam int unsigned TW = (MAX_CYC > 32'd1) ? $clog2(MAX_CYC) : 32'd1;
  localparam int unsigned CW = (CLEAR_CYCLES > 32'd1) ? $clog2(CLEAR_CYCLES) : 32'd1;

  // Timers count down from N-1 to 0, so each leg lasts exactly N cycles.
  localparam logic [TW-1:0] FWD_LOAD  = TW'(FWD_CYCLES - 32'd1);
  localparam logic [TW-1:0] TURN_LOAD = TW'(TURN_CYCLES - 32'd1);
  localparam logic [TW-1:0] BACK_LOAD = TW'(BACK_CYCLES - 32'd1);
  localparam logic [CW-1:0] CLR_LAST  = CW'(CLEAR_CYCLES - 32'd1);

  typedef enum logic [3:0] {
    IDLE_BASE   = 4'd0,
    FORWARDS    = 4'd1,
    TURN        = 4'd2,
    TO_TABLE    = 4'd3,
    IDLE_TABLE  = 4'd4,
    BACKWARDS   = 4'd5,
    TURN_BACK   = 4'd6,
    RETURN_HOME = 4'd7,
    STOP        = 4'd8
  } state_e;

  state_e        state_q, state_d;
  state_e        saved_q, saved_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] clear_q, clear_d;
  logic [2:0]    speed_q, speed_d;
  logic          changed_q, changed_d;
  logic          moving_s;

  // Next-state, timer, saved-state and clear-counter logic.
  always_comb begin
    state_d  = state_q;
    saved_d  = saved_q;
    timer_d  = timer_q;
    clear_d  = clear_q;
    moving_s = 1'b0;

    case (state_q)
      IDLE_BASE: begin
        if (go) begin
          state_d = FORWARDS;
          timer_d = FWD_LOAD;
        end else begin
          state_d = IDLE_BASE;
        end
      end
      FORWARDS: begin
        moving_s = 1'b1;
        if (timer_q == '0) begin
          state_d = TURN;
          timer_d = TURN_LOAD;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      TURN: begin
        moving_s = 1'b1;
        if (timer_q == '0) begin
          state_d = TO_TABLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      TO_TABLE: begin
        moving_s = 1'b1;
        if (arrived) begin
          state_d = IDLE_TABLE;
        end else begin
          state_d = TO_TABLE;
        end
      end
      IDLE_TABLE: begin
        if (pickup) begin
          state_d = BACKWARDS;
          timer_d = BACK_LOAD;
        end else begin
          state_d = IDLE_TABLE;
        end
      end
      BACKWARDS: begin
        moving_s = 1'b1;
        if (timer_q == '0) begin
          state_d = TURN_BACK;
          timer_d = TURN_LOAD;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      TURN_BACK: begin
        moving_s = 1'b1;
        if (timer_q == '0) begin
          state_d = RETURN_HOME;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      RETURN_HOME: begin
        moving_s = 1'b1;
        if (arrived) begin
          state_d = IDLE_BASE;
        end else begin
          state_d = RETURN_HOME;
        end
      end
      STOP: begin
        // Any blocked cycle restarts the clear window; the timer stays frozen.
        if (obstacle) begin
          clear_d = '0;
        end else if (clear_q == CLR_LAST) begin
          state_d = saved_q;
          clear_d = '0;
        end else begin
          clear_d = clear_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE_BASE;
        saved_d = IDLE_BASE;
        timer_d = '0;
        clear_d = '0;
      end
    endcase

    // Obstacle wins over expiry/arrived; the leg's timer is left untouched
    // so the tie is re-evaluated after resuming.
    if (moving_s && obstacle) begin
      state_d = STOP;
      saved_d = state_q;
      timer_d = timer_q;
      clear_d = '0;
    end else begin
      saved_d = saved_d;
    end
  end

  // Speed and transition pulse follow the next state so they line up with it.
  always_comb begin
    speed_d   = 3'd0;
    changed_d = (state_d != state_q);
    case (state_d)
      IDLE_BASE, IDLE_TABLE, STOP: speed_d = 3'd0;
      TO_TABLE, RETURN_HOME: begin
        if (near) begin
          speed_d = SPEED_SLOW;
        end else begin
          speed_d = SPEED_NORMAL;
        end
      end
      FORWARDS, TURN, BACKWARDS, TURN_BACK: speed_d = SPEED_NORMAL;
      default: speed_d = 3'd0;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE_BASE;
      saved_q   <= IDLE_BASE;
      timer_q   <= '0;
      clear_q   <= '0;
      speed_q   <= 3'd0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      saved_q   <= saved_d;
      timer_q   <= timer_d;
      clear_q   <= clear_d;
      speed_q   <= speed_d;
      changed_q <= changed_d;
    end
  end

  assign state         = state_q;
  assign speed         = speed_q;
  assign state_changed = changed_q;

endmodule

// File: tb/tb_waiter_nav_fsm.sv
// -----------------------------------------------------------------------------
// tb_waiter_nav_fsm
// Directed bench for waiter_nav_fsm with short leg parameters. Inputs change
// and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_waiter_nav_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       go, obstacle, near, arrived, pickup;
  logic [3:0] state;
  logic [2:0] speed;
  logic       state_changed;

  int n_checks = 0;
  int n_fail   = 0;
  int sc_count = 0;
  int sc_base;

  waiter_nav_fsm #(
    .FWD_CYCLES  (10),
    .TURN_CYCLES (5),
    .BACK_CYCLES (8),
    .CLEAR_CYCLES(3),
    .SPEED_NORMAL(3'd4),
    .SPEED_SLOW  (3'd1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .go           (go),
    .obstacle     (obstacle),
    .near         (near),
    .arrived      (arrived),
    .pickup       (pickup),
    .state        (state),
    .speed        (speed),
    .state_changed(state_changed)
  );

  always #5 clk = ~clk;

  // Count transition pulses seen on falling edges.
  always @(negedge clk) begin
    if (state_changed) sc_count <= sc_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Expect n consecutive cycles in state st at speed spd.
  task automatic expect_run(input string tag, input int st, input int n, input int spd);
    for (int i = 0; i < n; i++) begin
      check({tag, "_state"}, 32'(state), 32'(st));
      check({tag, "_speed"}, 32'(speed), 32'(spd));
      step();
    end
  endtask

  task automatic pulse_go();
    go = 1'b1; step(); go = 1'b0;
  endtask

  task automatic pulse_pickup();
    pickup = 1'b1; step(); pickup = 1'b0;
  endtask

  task automatic pulse_arrived();
    arrived = 1'b1; step(); arrived = 1'b0;
  endtask

  logic pat [6];

  initial begin
    rst_n = 1'b0; go = 1'b0; obstacle = 1'b0; near = 1'b0; arrived = 1'b0; pickup = 1'b0;
    pat[0] = 1'b0; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0; pat[4] = 1'b0; pat[5] = 1'b0;

    // Reset state
    repeat (2) step();
    check("rst_state", 32'(state), 32'd0);
    check("rst_speed", 32'(speed), 32'd0);
    check("rst_sc", 32'(state_changed), 32'd0);
    rst_n = 1'b1;
    step();
    check("idle_state", 32'(state), 32'd0);

    // Full delivery cycle
    #1 sc_base = sc_count;
    pulse_go();
    check("fwd_sc", 32'(state_changed), 32'd1);
    expect_run("fwd", 1, 10, 4);
    expect_run("turn", 2, 5, 4);
    expect_run("totab", 3, 3, 4);
    pulse_arrived();
    expect_run("idle_tab", 4, 2, 0);
    pulse_pickup();
    expect_run("back", 5, 8, 4);
    expect_run("turnb", 6, 5, 4);
    expect_run("home", 7, 2, 4);
    pulse_arrived();
    check("base_state", 32'(state), 32'd0);
    check("base_speed", 32'(speed), 32'd0);
    #1 check("sc_pulses", 32'(sc_count - sc_base), 32'd8);

    // Obstacle in the middle of FORWARDS: 4 cycles run, stop, 6 remain
    step();
    pulse_go();
    expect_run("fwd_a", 1, 4, 4);
    obstacle = 1'b1;
    step();
    check("stop_sc", 32'(state_changed), 32'd1);
    expect_run("stop_blk", 8, 5, 0);
    obstacle = 1'b0;
    expect_run("stop_clr", 8, 3, 0);
    check("resume_sc", 32'(state_changed), 32'd1);
    expect_run("fwd_b", 1, 6, 4);
    check("turn_after", 32'(state), 32'd2);
    expect_run("turn2", 2, 5, 4);

    // Glitchy clear in STOP; also obstacle beats arrived on entry
    obstacle = 1'b1; arrived = 1'b1;
    step();
    arrived = 1'b0;
    check("tie_stop", 32'(state), 32'd8);
    for (int i = 0; i < 6; i++) begin
      obstacle = pat[i];
      check("glitch_stop", 32'(state), 32'd8);
      step();
    end
    check("glitch_exit", 32'(state), 32'd3);
    check("glitch_sc", 32'(state_changed), 32'd1);

    // Slow-down near the table
    near = 1'b1;
    step();
    check("slow_speed", 32'(speed), 32'd1);
    check("slow_state", 32'(state), 32'd3);
    check("slow_sc", 32'(state_changed), 32'd0);
    near = 1'b0;
    step();
    check("fast_speed", 32'(speed), 32'd4);

    // Ignored inputs
    pulse_go();
    check("go_ign_state", 32'(state), 32'd3);
    check("go_ign_sc", 32'(state_changed), 32'd0);
    pulse_arrived();
    check("tab_state", 32'(state), 32'd4);
    obstacle = 1'b1;
    step();
    obstacle = 1'b0;
    check("obs_ign_state", 32'(state), 32'd4);
    check("obs_ign_sc", 32'(state_changed), 32'd0);

    // Async reset in BACKWARDS
    pulse_pickup();
    expect_run("back2", 5, 3, 4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_speed", 32'(speed), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    pulse_pickup();
    check("pick_ign_state", 32'(state), 32'd0);
    check("pick_ign_sc", 32'(state_changed), 32'd0);
    pulse_go();
    expect_run("fwd_rst", 1, 10, 4);
    check("turn_rst", 32'(state), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/waiter_nav_fsm.md
Name: waiter_nav_fsm

Overview:
- Top-level navigation sequencer for the waiter robot.
- Produces the 4-bit robot state and the 3-bit speed that the motor-drive stage uses to select its UART command sequences.
- Sequences one delivery cycle: base → table → base. Uses timed legs, sensor-terminated legs, and an obstacle-triggered STOP that resumes the interrupted leg.
- Inputs come from the FFT tone detector, the camera distance/obstacle logic and a pickup button.

Parameters:
- FWD_CYCLES, 100_000_000: duration of FORWARDS leg in clk cycles (2 s @ 50 MHz)
- TURN_CYCLES, 40_000_000: duration of TURN and of TURN_BACK
- BACK_CYCLES, 100_000_000: duration of BACKWARDS leg
- CLEAR_CYCLES, 25_000_000: consecutive obstacle-free cycles required before leaving STOP
- SPEED_NORMAL, 3'd4: speed code in moving states
- SPEED_SLOW, 3'd1: speed code in TO_TABLE/RETURN_HOME while near=1

Ports:
- clk  input  1  system clock (CLOCK_50)
- rst_n  input  1  asynchronous active-low reset
- go  input  1  1-cycle pulse from FFT detector: order received
- obstacle  input  1  level; path blocked (camera)
- near  input  1  level; target within slow-down distance
- arrived  input  1  level; target reached (table or base)
- pickup  input  1  1-cycle pulse; customer collected order
- state  output  4  robot state encoding (below)
- speed  output  3  speed code to motor stage
- state_changed  output  1  1-cycle pulse on any state transition

Behaviour:
- All inputs are synchronous to clk. Outputs are registered.
- Encoding:
  - IDLE_BASE=0, FORWARDS=1, TURN=2, TO_TABLE=3, IDLE_TABLE=4
  - BACKWARDS=5, TURN_BACK=6, RETURN_HOME=7, STOP=8
  - Codes 9–15 are never produced.
- Reset (async, rst_n=0): state=IDLE_BASE, speed=0, state_changed=0, timer=0, saved_state=IDLE_BASE, clear_cnt=0.
- Transitions, evaluated each rising edge:
  - IDLE_BASE: go=1 → FORWARDS, timer loaded with FWD_CYCLES-1.
  - FORWARDS: timer==0 → TURN, load TURN_CYCLES-1. Otherwise decrement.
  - TURN: timer==0 → TO_TABLE.
  - TO_TABLE: arrived=1 → IDLE_TABLE.
  - IDLE_TABLE: pickup=1 → BACKWARDS, load BACK_CYCLES-1.
  - BACKWARDS: timer==0 → TURN_BACK, load TURN_CYCLES-1.
  - TURN_BACK: timer==0 → RETURN_HOME.
  - RETURN_HOME: arrived=1 → IDLE_BASE.
- Leg timing: the FORWARDS, TURN, BACKWARDS and TURN_BACK legs each last exactly their parameter count of cycles.
- Obstacle handling (moving states 1,2,3,5,6,7 only):
  - obstacle=1 → STOP; saved_state=current state; timer frozen; clear_cnt=0.
  - Obstacle has priority over timer expiry and over arrived in the same cycle.
  - On resume after such a tie, the saved state is re-entered and expiry/arrived is evaluated from the following cycle.
- STOP:
  - obstacle=1 resets clear_cnt to 0. Otherwise clear_cnt increments.
  - When clear_cnt reaches CLEAR_CYCLES-1 with obstacle=0 → return to saved_state, timer resumes from its frozen value.
  - go, pickup and arrived are ignored in STOP.
- Ignored inputs:
  - obstacle is ignored in IDLE_BASE and IDLE_TABLE.
  - go is ignored outside IDLE_BASE.
  - pickup is ignored outside IDLE_TABLE.
  - arrived is ignored outside TO_TABLE/RETURN_HOME.
- speed, registered alongside state and valid in the same cycle as the new state:
  - 0 in IDLE_BASE, IDLE_TABLE, STOP.
  - SPEED_SLOW in TO_TABLE/RETURN_HOME when near=1.
  - SPEED_NORMAL in all other moving cases.
  - near changes update speed one cycle later, with no state change.
- state_changed: high for exactly the one cycle in which the state register holds a value different from the previous cycle. Includes STOP entry and exit.
- Widths:
  - Timer width = $clog2(max(FWD_CYCLES, TURN_CYCLES, BACK_CYCLES)).
  - clear_cnt width = $clog2(CLEAR_CYCLES).
  - All parameters must be ≥1. With value 1 the leg lasts one cycle.
- Reset mid-operation: immediate return to IDLE_BASE, speed=0. The saved state is discarded.

Test Plan:
Overrides for all scenarios: FWD=10, TURN=5, BACK=8, CLEAR=3, SPEED_NORMAL=4, SPEED_SLOW=1.
- Full cycle: go pulse → state 1 for 10 cycles, 2 for 5, 3 until arrived, 4. Then pickup → 5 for 8 cycles, 6 for 5, 7 until arrived, 0. state_changed pulses exactly 8 times; speed 4 in moving states, 0 in idle.
- Obstacle mid-FORWARDS: obstacle high at cycle 4 of FORWARDS for 6 cycles → state 8, speed 0. Return to 1 after 3 clear cycles; the remaining 6 FORWARDS cycles complete, then 2.
- Glitchy clear: in STOP, obstacle pattern 0,0,1,0,0,0 → exit only after the final three zeros.
- Slow-down: in TO_TABLE, near=1 → speed 1 the next cycle; near=0 → speed 4. State stays 3.
- Ignored inputs: go during TO_TABLE, pickup in IDLE_BASE, obstacle in IDLE_TABLE → no state change, no state_changed pulse.
- Async reset in BACKWARDS: rst_n low mid-cycle → state 0, speed 0 immediately, before the next edge. After release, a go pulse restarts the FORWARDS leg with the full 10 cycles.
